// File: rtl/mem_lsu_pkg.sv
// Shared encodings for the byte-serial load/store unit: access sizes,
// sequencer states, reset/write polarities and the per-size last-byte index.
package mem_lsu_pkg;

  localparam logic        RstEnable    = 1'b1;
  localparam logic        WriteEnable  = 1'b1;
  localparam logic        WriteDisable = 1'b0;
  localparam logic [31:0] ZeroWord     = 32'h0000_0000;

  localparam logic [1:0] SizeByte = 2'b00;
  localparam logic [1:0] SizeHalf = 2'b01;
  localparam logic [1:0] SizeWord = 2'b10;

  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StWait,
    StDone
  } lsu_state_e;

  // Index of the final byte of an access; size 11 behaves as a word.
  function automatic logic [1:0] last_idx(input logic [1:0] size);
    case (size)
      SizeByte: return 2'd0;
      SizeHalf: return 2'd1;
      default:  return 2'd3;
    endcase
  endfunction

endpackage

// File: rtl/mem_lsu_extend.sv
// Combinational load-data extender: selects byte, half or word from the
// assembled little-endian buffer and sign- or zero-extends it to 32 bits.
module lsu_extend
  import mem_lsu_pkg::*;
(
  input  logic [31:0] data_i,
  input  logic [1:0]  size_i,
  input  logic        sign_i,
  output logic [31:0] data_o
);

  always_comb begin
    case (size_i)
      SizeByte: data_o = {{24{sign_i & data_i[7]}}, data_i[7:0]};
      SizeHalf: data_o = {{16{sign_i & data_i[15]}}, data_i[15:0]};
      default:  data_o = data_i;
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// Byte-serial load/store unit between the MEM stage and an 8-bit RAM port.
// Sequences 1/2/4 byte transfers and holds the pipeline until completion.
module mem_lsu
  import mem_lsu_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy_in,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_sign,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              stall_req,
  output logic              done,
  output logic [31:0]       rdata,
  output logic [ADDR_W-1:0] mem_a,
  output logic [7:0]        mem_dout,
  output logic              mem_wr,
  input  logic [7:0]        mem_din
);

  lsu_state_e        state_q;
  logic              we_q;
  logic              sign_q;
  logic [1:0]        size_q;
  logic [1:0]        idx_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       buf_q;
  logic [31:0]       rdata_q;

  logic [1:0]  last_byte;
  logic [1:0]  cap_idx;
  logic [31:0] buf_d;
  logic [31:0] ext_data;
  logic        wr_phase;

  assign last_byte = last_idx(size_q);

  // RAM data arrives one cycle late, so it belongs to the previous index;
  // in WAIT it is the final byte of the access.
  // NOTE: every signal written in always_comb gets a value on every path
  // (defaults first), otherwise synthesis infers a latch.
  always_comb begin
    buf_d   = buf_q;
    cap_idx = (state_q == StWait) ? last_byte : idx_q - 2'd1;
    buf_d[{cap_idx, 3'b000} +: 8] = mem_din;
  end

  lsu_extend u_extend (
    .data_i (buf_d),
    .size_i (size_q),
    .sign_i (sign_q),
    .data_o (ext_data)
  );

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of every other register.
  // NOTE: the data buffer is plain flops, so it is reset along with the
  // control state to keep rdata defined at 0 straight out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst == RstEnable) begin
      state_q <= StIdle;
      we_q    <= 1'b0;
      sign_q  <= 1'b0;
      size_q  <= SizeByte;
      idx_q   <= 2'd0;
      addr_q  <= '0;
      wdata_q <= ZeroWord;
      buf_q   <= ZeroWord;
      rdata_q <= ZeroWord;
    end else if (rdy_in) begin
      case (state_q)
        StIdle: begin
          if (req_valid) begin
            we_q    <= req_we;
            sign_q  <= req_sign;
            size_q  <= req_size;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            idx_q   <= 2'd0;
            buf_q   <= ZeroWord;
            state_q <= StAccess;
          end
        end
        StAccess: begin
          if (!we_q && idx_q != 2'd0) buf_q <= buf_d;
          if (idx_q == last_byte) begin
            if (we_q) begin
              rdata_q <= ZeroWord;
              state_q <= StDone;
            end else begin
              state_q <= StWait;
            end
          end else begin
            idx_q <= idx_q + 2'd1;
          end
        end
        StWait: begin
          buf_q   <= buf_d;
          rdata_q <= ext_data;
          state_q <= StDone;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // idx_q stays on the last byte through WAIT, so mem_a holds the last address.
  assign wr_phase  = (state_q == StAccess) && (we_q == WriteEnable);
  assign mem_wr    = (wr_phase && rdy_in) ? WriteEnable : WriteDisable;
  assign mem_dout  = wr_phase ? wdata_q[{idx_q, 3'b000} +: 8] : 8'h00;
  assign mem_a     = (state_q == StIdle) ? '0 : addr_q + ADDR_W'(idx_q);
  assign done      = (state_q == StDone) && rdy_in;
  assign stall_req = ((state_q == StIdle) && req_valid) ||
                     (state_q == StAccess) || (state_q == StWait);
  assign rdata     = rdata_q;

endmodule

// File: tb/tb_mem_lsu.sv
// Self-checking bench for mem_lsu: cycle-count reference model plus a byte RAM
// with one-cycle read latency, and directed vectors with literal expectations.
module tb_mem_lsu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rdy_in = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_sign = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        stall_req;
  logic        done;
  logic [31:0] rdata;
  logic [31:0] mem_a;
  logic [7:0]  mem_dout;
  logic        mem_wr;
  logic [7:0]  mem_din = 8'h00;

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;

  mem_lsu #(.ADDR_W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .rdy_in    (rdy_in),
    .req_valid (req_valid),
    .req_we    (req_we),
    .req_size  (req_size),
    .req_sign  (req_sign),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .stall_req (stall_req),
    .done      (done),
    .rdata     (rdata),
    .mem_a     (mem_a),
    .mem_dout  (mem_dout),
    .mem_wr    (mem_wr),
    .mem_din   (mem_din)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, got, exp, cyc);
  endtask

  // Byte RAM: synchronous read, one-cycle latency, stalls with rdy_in.
  logic [7:0] ram [logic [31:0]];

  function automatic logic [7:0] rd(input logic [31:0] a);
    return ram.exists(a) ? ram[a] : 8'h00;
  endfunction

  always @(posedge clk) begin
    if (rdy_in) begin
      mem_din <= rd(mem_a);
      if (mem_wr) ram[mem_a] = mem_dout;
    end
  end

  // Expected extended load value straight from the RAM contents.
  function automatic logic [31:0] exp_load(input logic [31:0] a, input logic [1:0] sz,
                                           input logic sg);
    logic [31:0] w;
    int v;
    w = {rd(a + 32'd3), rd(a + 32'd2), rd(a + 32'd1), rd(a)};
    if (sz == 2'b00)      v = sg ? int'($signed(w[7:0]))  : int'(w[7:0]);
    else if (sz == 2'b01) v = sg ? int'($signed(w[15:0])) : int'(w[15:0]);
    else                  v = int'(w);
    return 32'(v);
  endfunction

  // Per-cycle trace for the directed literal checks.
  logic        tr_wr    [4096];
  logic [31:0] tr_a     [4096];
  logic [7:0]  tr_d     [4096];
  logic        tr_stall [4096];

  // Reference model: k counts un-paused cycles since acceptance.
  // Store: bytes at k=1..N, done at N+1. Load: addresses k=1..N, done at N+2.
  logic        m_busy = 1'b0;
  int          m_k, m_n, m_final;
  logic        m_we;
  logic [31:0] m_addr, m_wdata, m_exp;
  logic [31:0] m_rdata = 32'h0;

  always @(negedge clk) begin
    if (cyc < 4096) begin
      tr_wr[cyc]    = mem_wr;
      tr_a[cyc]     = mem_a;
      tr_d[cyc]     = mem_dout;
      tr_stall[cyc] = stall_req;
    end
    if (rst) begin
      m_busy  = 1'b0;
      m_rdata = 32'h0;
      check("rst_wr", 32'(mem_wr), 32'h0);
      check("rst_done", 32'(done), 32'h0);
      check("rst_mem_a", mem_a, 32'h0);
      check("rst_rdata", rdata, 32'h0);
      check("rst_stall", 32'(stall_req), 32'(req_valid));
    end else if (!m_busy) begin
      check("idle_stall", 32'(stall_req), 32'(req_valid));
      check("idle_done", 32'(done), 32'h0);
      check("idle_wr", 32'(mem_wr), 32'h0);
      check("idle_mem_a", mem_a, 32'h0);
      check("idle_rdata_hold", rdata, m_rdata);
      if (req_valid && rdy_in) begin
        m_busy  = 1'b1;
        m_k     = 1;
        m_we    = req_we;
        m_addr  = req_addr;
        m_wdata = req_wdata;
        m_n     = (req_size == 2'b00) ? 1 : (req_size == 2'b01) ? 2 : 4;
        m_final = req_we ? m_n + 1 : m_n + 2;
        m_exp   = req_we ? 32'h0 : exp_load(req_addr, req_size, req_sign);
      end
    end else begin
      check("busy_stall", 32'(stall_req), 32'(m_k < m_final));
      check("busy_done", 32'(done), 32'(m_k == m_final && rdy_in));
      check("busy_wr", 32'(mem_wr), 32'(m_we && m_k <= m_n && rdy_in));
      if (m_k <= m_n) begin
        check("busy_mem_a", mem_a, m_addr + 32'(m_k - 1));
        if (m_we) check("busy_dout", 32'(mem_dout), 32'(m_wdata[8*(m_k-1) +: 8]));
      end else if (!m_we && m_k == m_n + 1) begin
        check("wait_mem_a", mem_a, m_addr + 32'(m_n - 1));
      end
      if (m_k == m_final) check("done_rdata", rdata, m_exp);
      if (rdy_in) begin
        if (m_k == m_final) begin
          m_busy  = 1'b0;
          m_rdata = m_exp;
        end else begin
          m_k++;
        end
      end
    end
  end

  // One request; rdy_in low for relative cycles [pause_at, pause_at+pause_len).
  task automatic issue(input logic we, input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [31:0] wd,
                       input int pause_at, input int pause_len,
                       output int t0, output int t_done, output logic [31:0] rd_out);
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = we; req_size = sz; req_sign = sg;
    req_addr = a; req_wdata = wd; rdy_in = 1'b1;
    t0 = cyc;
    t_done = -1;
    rd_out = 32'hx;
    for (int rel = 1; rel < 40; rel++) begin
      @(posedge clk); #1;
      req_valid = 1'b0; req_we = ~we; req_size = ~sz; req_sign = ~sg;
      req_addr = ~a; req_wdata = ~wd;
      rdy_in = !(rel >= pause_at && rel < pause_at + pause_len);
      @(negedge clk);
      if (done) begin
        t_done = rel;
        rd_out = rdata;
        break;
      end
    end
    rdy_in = 1'b1;
    if (t_done < 0) check("done_timeout", 32'hFFFF_FFFF, 32'h0);
  endtask

  int t0, td;
  logic [31:0] r;
  logic seen;

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_dout", 32'(mem_dout), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Store word, then read it back.
    issue(1'b1, 2'b10, 1'b0, 32'h100, 32'hDEADBEEF, -1, 0, t0, td, r);
    check("sw_done_cycle", 32'(td), 32'd5);
    check("sw_a1", tr_a[t0+1], 32'h100);  check("sw_d1", 32'(tr_d[t0+1]), 32'hEF);
    check("sw_a2", tr_a[t0+2], 32'h101);  check("sw_d2", 32'(tr_d[t0+2]), 32'hBE);
    check("sw_a3", tr_a[t0+3], 32'h102);  check("sw_d3", 32'(tr_d[t0+3]), 32'hAD);
    check("sw_a4", tr_a[t0+4], 32'h103);  check("sw_d4", 32'(tr_d[t0+4]), 32'hDE);
    for (int c = 1; c <= 4; c++) check("sw_wr", 32'(tr_wr[t0+c]), 32'h1);
    for (int c = 0; c <= 4; c++) check("sw_stall", 32'(tr_stall[t0+c]), 32'h1);
    check("sw_stall_done", 32'(tr_stall[t0+5]), 32'h0);
    check("sw_rdata", r, 32'h0);
    issue(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, -1, 0, t0, td, r);
    check("lw_done_cycle", 32'(td), 32'd6);
    check("lw_rdata", r, 32'hDEADBEEF);

    // Byte loads, signed and unsigned.
    issue(1'b1, 2'b00, 1'b0, 32'h20, 32'h1234_5680, -1, 0, t0, td, r);
    check("sb_done_cycle", 32'(td), 32'd2);
    issue(1'b0, 2'b00, 1'b1, 32'h20, 32'h0, -1, 0, t0, td, r);
    check("lb_done_cycle", 32'(td), 32'd3);
    check("lb_signed", r, 32'hFFFFFF80);
    issue(1'b0, 2'b00, 1'b0, 32'h20, 32'h0, -1, 0, t0, td, r);
    check("lbu_unsigned", r, 32'h00000080);

    // Unaligned half, plain and with a pause during the capture.
    issue(1'b1, 2'b01, 1'b0, 32'h31, 32'h0000_F234, -1, 0, t0, td, r);
    issue(1'b0, 2'b01, 1'b1, 32'h31, 32'h0, -1, 0, t0, td, r);
    check("lh_done_cycle", 32'(td), 32'd4);
    check("lh_signed", r, 32'hFFFFF234);
    issue(1'b0, 2'b01, 1'b1, 32'h31, 32'h0, 2, 2, t0, td, r);
    check("lh_pause_done_cycle", 32'(td), 32'd6);
    check("lh_pause_rdata", r, 32'hFFFFF234);

    // Address wrap at the top of the address space.
    issue(1'b1, 2'b10, 1'b0, 32'hFFFF_FFFE, 32'h4433_2211, -1, 0, t0, td, r);
    check("sw_wrap_a3", tr_a[t0+3], 32'h0);
    issue(1'b0, 2'b10, 1'b0, 32'hFFFF_FFFE, 32'h0, -1, 0, t0, td, r);
    check("lw_wrap_a1", tr_a[t0+1], 32'hFFFF_FFFE);
    check("lw_wrap_a2", tr_a[t0+2], 32'hFFFF_FFFF);
    check("lw_wrap_a3", tr_a[t0+3], 32'h0000_0000);
    check("lw_wrap_a4", tr_a[t0+4], 32'h0000_0001);
    check("lw_wrap_rdata", r, 32'h44332211);

    // Store half with a 3-cycle pause starting in cycle 2.
    issue(1'b1, 2'b01, 1'b0, 32'h200, 32'h0000_A5C3, 2, 3, t0, td, r);
    check("sh_pause_done_cycle", 32'(td), 32'd6);
    check("sh_pause_wr1", 32'(tr_wr[t0+1]), 32'h1);
    check("sh_pause_d1", 32'(tr_d[t0+1]), 32'hC3);
    for (int c = 2; c <= 4; c++) check("sh_pause_no_wr", 32'(tr_wr[t0+c]), 32'h0);
    check("sh_pause_wr5", 32'(tr_wr[t0+5]), 32'h1);
    check("sh_pause_a5", tr_a[t0+5], 32'h201);
    check("sh_pause_d5", 32'(tr_d[t0+5]), 32'hA5);
    issue(1'b0, 2'b01, 1'b0, 32'h200, 32'h0, -1, 0, t0, td, r);
    check("lhu_readback", r, 32'h0000A5C3);

    // Size 11 behaves as word; half at an odd-half offset zero-extended.
    issue(1'b0, 2'b11, 1'b1, 32'h100, 32'h0, -1, 0, t0, td, r);
    check("size11_rdata", r, 32'hDEADBEEF);
    issue(1'b0, 2'b01, 1'b0, 32'h102, 32'h0, -1, 0, t0, td, r);
    check("lhu_hi_rdata", r, 32'h0000DEAD);

    // Reset during ACCESS of a word store.
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_sign = 1'b0;
    req_addr = 32'h300; req_wdata = 32'h1122_3344;
    t0 = cyc;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("rstmid_wr", 32'(mem_wr), 32'h0);
    check("rstmid_stall", 32'(stall_req), 32'h0);
    check("rstmid_dout", 32'(mem_dout), 32'h0);
    check("rstmid_rdata", rdata, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    check("rstmid_no_done", 32'(seen), 32'h0);
    check("rstmid_first_wr", 32'(tr_wr[t0+1]), 32'h1);
    issue(1'b0, 2'b10, 1'b0, 32'h300, 32'h0, -1, 0, t0, td, r);
    check("rstmid_partial", r, 32'h00000044);
    check("rstmid_next_done_cycle", 32'(td), 32'd6);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
